voice_mix_scheduler: RTL
========================

# voice_mix_scheduler

Time-multiplexed envelope-and-mix engine for the polyphonic voice bank. A single signed audio×envelope multiplier is shared across NUM_VOICES voices. One voice is issued per clock after each sample tick, the scaled products are summed, and one mixed sample is emitted per sweep. It sits between the per-voice oscillator/ADSR outputs and the output filter/DAC path, replacing one multiplier per voice.

## Interface
- NUM_VOICES, 8, voices per sweep (≥2)
- DATA_WIDTH, 32, audio sample width (signed)
- ENVELOPE_WIDTH, 32, envelope width; 2^(EW-1)-1 ≈ 1.0
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- sample_tick  in  1  start-of-sweep strobe, one cycle
- voice_audio  in  NUM_VOICES*DATA_WIDTH  signed samples, voice i at [i*DW +: DW]
- voice_env  in  NUM_VOICES*ENVELOPE_WIDTH  envelopes, voice i at [i*EW +: EW]
- voice_active  in  NUM_VOICES  bit i enables voice i
- mix_out  out  DATA_WIDTH  signed mixed sample, held until next result
- mix_valid  out  1  one-cycle pulse when mix_out updates
- busy  out  1  sweep in progress
- overrun  out  1  one-cycle pulse: tick arrived while busy

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE + sample_tick:
  - snapshot voice_audio, voice_env and voice_active into internal registers;
  - clear the accumulator; idx=0; go to SCAN.
  - Source inputs may change after the tick.
- SCAN: issue snapshot voice idx to the multiplier each cycle, idx++.
  - After idx=NUM_VOICES-1, go to DRAIN.
- DRAIN: 2 cycles to flush the multiply and accumulate stages, then IDLE. mix_out and mix_valid are registered on the DRAIN→IDLE edge.
- Multiply: full product = signed audio × signed'(envelope), DW+EW bits.
- Scale: product[DW+EW-2 : EW-1], i.e. arithmetic >> (EW-1), truncated toward −∞.
- Inactive voice: product forced to 0. The voice still occupies its slot, so latency is constant.
- Accumulator: signed, DW+$clog2(NUM_VOICES) bits, cannot overflow.
- Final result reduced to DW bits per Configuration.
- sample_tick in SCAN/DRAIN: ignored, overrun pulses the following cycle, current sweep unaffected.
- sample_tick in the cycle mix_valid is high: state is IDLE, so the tick is accepted normally.
- rst at any time:
  - state=IDLE, idx=0, accumulator and pipeline cleared;
  - mix_out=0, mix_valid=0, busy=0, overrun=0;
  - an aborted sweep produces no mix_valid.

## Timing
- Tick sampled in cycle T.
- busy=1 in cycles T+1 … T+NUM_VOICES+2.
- Voice i issued in T+1+i; product registered in T+2+i; accumulated in T+3+i.
- mix_valid=1 and new mix_out in cycle T+NUM_VOICES+3 (T+11 at default); busy=0 in that cycle.
- Minimum tick spacing: NUM_VOICES+3 cycles. Ticks at 48 kHz are far slower.
- Throughput: one multiply per cycle; no stalls, no backpressure.

## Configuration
- VOICE_MIX_SATURATE_EN defined: final sum clamped to [−2^(DW-1), 2^(DW-1)−1].
- VOICE_MIX_SATURATE_EN undefined: low DW bits of the accumulator, two's-complement wrap.

## Test plan
- Voice 0 active only, audio=0x4000_0000, env=0x7FFF_FFFF, tick at T → mix_out=0x3FFF_FFFF, mix_valid pulse only in T+11, busy high in T+1…T+10.
- All 8 active, audio=0x4000_0000, env=0x7FFF_FFFF → mix_out=0x7FFF_FFFF with VOICE_MIX_SATURATE_EN; 0xFFFF_FFF8 without.
- All 8 active, audio=0x8000_0000, env=0x7FFF_FFFF → saturated 0x8000_0000; with voice 0 only active → 0x8000_0001.
- voice_active=0x00, nonzero audio/env → mix_valid at T+11 with mix_out=0; inputs changed at T+1 do not alter the result.
- Second tick at T+4 → overrun pulse at T+5, single mix_valid at T+11, result unchanged. Tick at T+11 (coincident with mix_valid) → accepted, next mix_valid at T+22, no overrun.
- rst asserted at T+5 → busy=0, mix_out=0 from T+6, no mix_valid. A new tick after reset gives a correct result 11 cycles later.

Source files
------------

// File: rtl/voice_mix_scheduler_if.sv
// Bundle between the voice bank and the mix scheduler.
// master: voice bank / sequencer side, drives the tick and the voice data.
// slave : the scheduler, returns the mixed sample and status.
interface voice_mix_scheduler_if #(
  parameter int NUM_VOICES     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int ENVELOPE_WIDTH = 32
);
  logic                                 sample_tick;
  logic [NUM_VOICES*DATA_WIDTH-1:0]     voice_audio;
  logic [NUM_VOICES*ENVELOPE_WIDTH-1:0] voice_env;
  logic [NUM_VOICES-1:0]                voice_active;
  logic [DATA_WIDTH-1:0]                mix_out;
  logic                                 mix_valid;
  logic                                 busy;
  logic                                 overrun;

  modport master (
    output sample_tick, voice_audio, voice_env, voice_active,
    input  mix_out, mix_valid, busy, overrun
  );

  modport slave (
    input  sample_tick, voice_audio, voice_env, voice_active,
    output mix_out, mix_valid, busy, overrun
  );
endinterface

// File: rtl/voice_mix_scheduler.sv
// Time-multiplexed envelope-and-mix engine: one shared signed multiplier
// scales each voice by its envelope, one voice per clock, and the scaled
// products are summed into one mixed sample per sweep.
//
// Build option: define VOICE_MIX_SATURATE_EN to clamp the final sum to the
// DATA_WIDTH signed range; otherwise the low DATA_WIDTH bits wrap.
//
// state | meaning
// IDLE  | waiting for sample_tick; mix_out holds the last result
// SCAN  | issuing snapshot voice idx to the multiplier, one per cycle
// DRAIN | two cycles flushing the multiply and accumulate stages
module voice_mix_scheduler #(
  parameter int NUM_VOICES     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int ENVELOPE_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  voice_mix_scheduler_if.slave  bus
);

  localparam int DW     = DATA_WIDTH;
  localparam int EW     = ENVELOPE_WIDTH;
  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int ACC_W  = DW + $clog2(NUM_VOICES);
  localparam int PROD_W = DW + EW;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic                           drain_q, drain_d;
  logic [NUM_VOICES*DW-1:0]       audio_snap_q, audio_snap_d;
  logic [NUM_VOICES*EW-1:0]       env_snap_q, env_snap_d;
  logic [NUM_VOICES-1:0]          active_snap_q, active_snap_d;
  logic [DW-1:0]                  prod_q, prod_d;
  logic                           prod_vld_q, prod_vld_d;
  logic [ACC_W-1:0]               acc_q, acc_d;
  logic [DW-1:0]                  mix_out_q, mix_out_d;
  logic                           mix_valid_q, mix_valid_d;
  logic                           overrun_q, overrun_d;

  logic signed [DW-1:0]           cur_audio;
  logic signed [EW-1:0]           cur_env;
  logic                           cur_active;
  logic signed [PROD_W-1:0]       prod_full;
  logic [DW-1:0]                  prod_scaled;
  logic                           prod_unused;
  logic [DW-1:0]                  mix_reduced;

  // Shared multiplier: select the current voice and scale by envelope (>> EW-1, floor).
  always_comb begin
    cur_audio   = audio_snap_q[int'(idx_q)*DW +: DW];
    cur_env     = env_snap_q[int'(idx_q)*EW +: EW];
    cur_active  = active_snap_q[idx_q];
    prod_full   = $signed({{EW{cur_audio[DW-1]}}, cur_audio}) *
                  $signed({{DW{cur_env[EW-1]}}, cur_env});
    prod_scaled = prod_full[PROD_W-2:EW-1];
    // Top bit is a redundant sign copy; low bits are discarded by the scaling.
    prod_unused = ^{prod_full[PROD_W-1], prod_full[EW-2:0]};
  end

  // Reduce the wide accumulator to the output width.
`ifdef VOICE_MIX_SATURATE_EN
  always_comb begin
    if ((acc_q[ACC_W-1:DW-1] == '0) || (acc_q[ACC_W-1:DW-1] == '1)) begin
      mix_reduced = acc_q[DW-1:0];
    end else if (acc_q[ACC_W-1]) begin
      mix_reduced = {1'b1, {(DW-1){1'b0}}};
    end else begin
      mix_reduced = {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  logic acc_unused;
  always_comb begin
    mix_reduced = acc_q[DW-1:0];
    acc_unused  = ^acc_q[ACC_W-1:DW];
  end
`endif

  // Next-state, snapshot, pipeline and output logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    drain_d       = drain_q;
    audio_snap_d  = audio_snap_q;
    env_snap_d    = env_snap_q;
    active_snap_d = active_snap_q;
    prod_d        = cur_active ? prod_scaled : '0;
    prod_vld_d    = (state_q == SCAN);
    acc_d         = prod_vld_q ? acc_q + {{(ACC_W-DW){prod_q[DW-1]}}, prod_q} : acc_q;
    mix_out_d     = mix_out_q;
    mix_valid_d   = 1'b0;
    overrun_d     = bus.sample_tick && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (bus.sample_tick) begin
          audio_snap_d  = bus.voice_audio;
          env_snap_d    = bus.voice_env;
          active_snap_d = bus.voice_active;
          acc_d         = '0;
          idx_d         = '0;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          idx_d   = '0;
          drain_d = 1'b0;
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!drain_q) begin
          drain_d = 1'b1;
        end else begin
          drain_d     = 1'b0;
          mix_out_d   = mix_reduced;
          mix_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      drain_q       <= 1'b0;
      audio_snap_q  <= '0;
      env_snap_q    <= '0;
      active_snap_q <= '0;
      prod_q        <= '0;
      prod_vld_q    <= 1'b0;
      acc_q         <= '0;
      mix_out_q     <= '0;
      mix_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      drain_q       <= drain_d;
      audio_snap_q  <= audio_snap_d;
      env_snap_q    <= env_snap_d;
      active_snap_q <= active_snap_d;
      prod_q        <= prod_d;
      prod_vld_q    <= prod_vld_d;
      acc_q         <= acc_d;
      mix_out_q     <= mix_out_d;
      mix_valid_q   <= mix_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.mix_out   = mix_out_q;
  assign bus.mix_valid = mix_valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.overrun   = overrun_q;

endmodule
